// File: rtl/kinase_activity_ctrl_if.sv
// Host/manifold control bus of the kinase activity sequencer.
// The host (master) drives start/abort and watches the handshake and phase.
// The sequencer (slave) drives the pneumatic valve, sieve and pump lines.
interface kinase_activity_ctrl_if;
  logic        start;
  logic        abort;
  logic [12:0] c;
  logic [3:0]  s;
  logic [4:0]  p;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [2:0]  phase;

  modport master (
    output start, abort,
    input  c, s, p, busy, done, aborted, phase
  );

  modport slave (
    input  start, abort,
    output c, s, p, busy, done, aborted, phase
  );
endinterface

// File: rtl/kinase_activity_ctrl.sv
// Assay sequencer for the dual kinase activity chip array.
// One run walks LOAD -> MIX -> INC -> FLUSH and back to IDLE, driving the
// shared valve (c), sieve (s) and pump (p) lines. Every output is registered
// and is decoded from the next state, so the line vectors change on the same
// edge as the state register. abort drops any active run to the all-closed
// IDLE state; it has no effect while IDLE.
module kinase_activity_ctrl #(
  parameter int LOAD_CYC  = 8,
  parameter int STEP_CYC  = 4,
  parameter int MIX_REPS  = 2,
  parameter int INC_CYC   = 16,
  parameter int FLUSH_CYC = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  kinase_activity_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MIX   = 3'd2,
    ST_INC   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  // Durations below one cycle collapse to a single cycle.
  localparam int LOAD_N  = (LOAD_CYC  < 1) ? 1 : LOAD_CYC;
  localparam int STEP_N  = (STEP_CYC  < 1) ? 1 : STEP_CYC;
  localparam int REPS_N  = (MIX_REPS  < 1) ? 1 : MIX_REPS;
  localparam int INC_N   = (INC_CYC   < 1) ? 1 : INC_CYC;
  localparam int FLUSH_N = (FLUSH_CYC < 1) ? 1 : FLUSH_CYC;
  localparam int MIX_N   = REPS_N * 6 * STEP_N;

  // Terminal values of the 16-bit phase counter and the step counter.
  localparam logic [15:0] LOAD_LAST  = 16'(LOAD_N - 1);
  localparam logic [15:0] MIX_LAST   = 16'(MIX_N - 1);
  localparam logic [15:0] INC_LAST   = 16'(INC_N - 1);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_N - 1);
  localparam logic [15:0] STEP_LAST  = 16'(STEP_N - 1);

  // Line vectors for each phase.
  localparam logic [12:0] C_IDLE  = 13'h1FFF;
  localparam logic [12:0] C_LOAD  = 13'h0078;
  localparam logic [12:0] C_MIX   = 13'h007F;
  localparam logic [12:0] C_INC   = 13'h1FFF;
  localparam logic [12:0] C_FLUSH = 13'h0006;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] step_q, step_d;
  logic [2:0]  idx_q, idx_d;
  logic        tog_q, tog_d;
  logic        step_wrap;

  logic [12:0] c_d, c_q;
  logic [3:0]  s_d, s_q;
  logic [4:0]  p_d, p_q;
  logic        busy_q, done_d, done_q, aborted_d, aborted_q;

  assign step_wrap = (step_q == STEP_LAST);

  // Next-state, counter and handshake-pulse logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    step_d    = step_q;
    idx_d     = idx_q;
    tog_d     = tog_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.start && !bus.abort) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_MIX;
          cnt_d   = '0;
          step_d  = '0;
          idx_d   = '0;
        end
      end

      ST_MIX: begin
        // Advance the peristaltic pattern every STEP_N cycles, wrapping 5 -> 0.
        if (step_wrap) begin
          step_d = '0;
          idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
          step_d = step_q + 16'd1;
        end
        if (cnt_q == MIX_LAST) begin
          state_d = ST_INC;
          cnt_d   = '0;
        end
      end

      ST_INC: begin
        if (cnt_q == INC_LAST) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
          step_d  = '0;
          idx_d   = '0;
          tog_d   = 1'b0;
        end
      end

      ST_FLUSH: begin
        // Alternate the two flush pump lines every STEP_N cycles.
        if (step_wrap) begin
          step_d = '0;
          tog_d  = ~tog_q;
        end else begin
          step_d = step_q + 16'd1;
        end
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort beats every other transition, including a completing FLUSH.
    if (bus.abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // Line vectors for the state being entered, so they register alongside it.
  always_comb begin
    c_d = C_IDLE;
    s_d = 4'h0;
    p_d = 5'h00;
    case (state_d)
      ST_LOAD: begin
        c_d = C_LOAD;
        s_d = 4'hF;
      end
      ST_MIX: begin
        c_d = C_MIX;
        s_d = 4'hF;
        case (idx_d)
          3'd0:    p_d = 5'b00101;
          3'd1:    p_d = 5'b00100;
          3'd2:    p_d = 5'b00110;
          3'd3:    p_d = 5'b00010;
          3'd4:    p_d = 5'b00011;
          default: p_d = 5'b00001;
        endcase
      end
      ST_INC: begin
        c_d = C_INC;
        s_d = 4'hF;
      end
      ST_FLUSH: begin
        c_d = C_FLUSH;
        p_d = tog_d ? 5'b01000 : 5'b10000;
      end
      default: begin
        c_d = C_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset forces the safe state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      step_q    <= '0;
      idx_q     <= '0;
      tog_q     <= 1'b0;
      c_q       <= C_IDLE;
      s_q       <= 4'h0;
      p_q       <= 5'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      idx_q     <= idx_d;
      tog_q     <= tog_d;
      c_q       <= c_d;
      s_q       <= s_d;
      p_q       <= p_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.c       = c_q;
  assign bus.s       = s_q;
  assign bus.p       = p_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.phase   = state_q;

endmodule

// File: tb/tb_kinase_activity_ctrl.sv
// Directed bench for kinase_activity_ctrl with default parameters.
// Each step drives start/abort for one cycle and pushes the outputs expected
// after the following edge; the check pops and compares them at the falling
// edge. Expected values come from a timeline of a default-length run.
module tb_kinase_activity_ctrl;

  typedef struct packed {
    logic [2:0]  phase;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [12:0] c;
    logic [3:0]  s;
    logic [4:0]  p;
  } obs_t;

  logic clk;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;
  obs_t sb_q[$];

  kinase_activity_ctrl_if bus ();

  kinase_activity_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs expected while IDLE.
  function automatic obs_t idle_exp(input logic dn, input logic ab);
    obs_t e;
    e.phase   = 3'd0;
    e.busy    = 1'b0;
    e.done    = dn;
    e.aborted = ab;
    e.c       = 13'h1FFF;
    e.s       = 4'h0;
    e.p       = 5'h00;
    return e;
  endfunction

  // Outputs expected in cycle k of a run whose start was sampled at edge 0.
  function automatic obs_t exp_run(input int k);
    obs_t e;
    e = idle_exp(1'b0, 1'b0);
    e.busy = 1'b1;
    if (k < 8) begin
      e.phase = 3'd1; e.c = 13'h0078; e.s = 4'hF; e.p = 5'h00;
    end else if (k < 56) begin
      e.phase = 3'd2; e.c = 13'h007F; e.s = 4'hF;
      case (((k - 8) / 4) % 6)
        0:       e.p = 5'b00101;
        1:       e.p = 5'b00100;
        2:       e.p = 5'b00110;
        3:       e.p = 5'b00010;
        4:       e.p = 5'b00011;
        default: e.p = 5'b00001;
      endcase
    end else if (k < 72) begin
      e.phase = 3'd3; e.c = 13'h1FFF; e.s = 4'hF; e.p = 5'h00;
    end else if (k < 80) begin
      e.phase = 3'd4; e.c = 13'h0006; e.s = 4'h0;
      e.p = ((((k - 72) / 4) % 2) == 0) ? 5'b10000 : 5'b01000;
    end else begin
      e = idle_exp(1'b1, 1'b0);
    end
    return e;
  endfunction

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check(input string tag);
    obs_t act, exp;
    act = '{phase: bus.phase, busy: bus.busy, done: bus.done,
            aborted: bus.aborted, c: bus.c, s: bus.s, p: bus.p};
    n_asserts++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: no expected entry queued, observed %h", tag, act);
    end else begin
      exp = sb_q.pop_front();
      assert (act === exp) else begin
        n_fail++;
        $error("FAIL %s: observed ph=%0d busy=%b done=%b ab=%b c=%h s=%h p=%b, expected ph=%0d busy=%b done=%b ab=%b c=%h s=%h p=%b",
               tag, act.phase, act.busy, act.done, act.aborted, act.c, act.s, act.p,
               exp.phase, exp.busy, exp.done, exp.aborted, exp.c, exp.s, exp.p);
      end
    end
  endtask

  // Drive inputs for one cycle, queue the expected result of the next edge.
  task automatic step(input logic st, input logic ab, input obs_t e, input string tag);
    bus.start = st;
    bus.abort = ab;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  // Cycles k0..k1 of a run, start held at st and abort low.
  task automatic run_span(input int k0, input int k1, input logic st, input string nm);
    for (int k = k0; k <= k1; k++) begin
      step(st, 1'b0, exp_run(k), $sformatf("%s_c%0d", nm, k));
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Reset state.
    #1;
    sb_q.push_back(idle_exp(1'b0, 1'b0));
    check("reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, idle_exp(1'b0, 1'b0), "idle_quiet");

    // Full default run: phases, mix pattern, flush toggling, done pulse.
    step(1'b1, 1'b0, exp_run(0), "run1_c0");
    run_span(1, 80, 1'b0, "run1");
    step(1'b0, 1'b0, idle_exp(1'b0, 1'b0), "run1_after_done");

    // Abort during MIX in cycle 20.
    step(1'b1, 1'b0, exp_run(0), "abm_c0");
    run_span(1, 20, 1'b0, "abm");
    step(1'b0, 1'b1, idle_exp(1'b0, 1'b1), "abort_mix");
    step(1'b0, 1'b0, idle_exp(1'b0, 1'b0), "abort_mix_after");

    // start pulsed mid-run is ignored; start+abort in IDLE does nothing.
    step(1'b1, 1'b0, exp_run(0), "rst30_c0");
    run_span(1, 30, 1'b0, "ign");
    step(1'b1, 1'b0, exp_run(31), "start_while_busy");
    run_span(32, 80, 1'b0, "ign");
    step(1'b0, 1'b0, idle_exp(1'b0, 1'b0), "ign_after_done");
    step(1'b1, 1'b1, idle_exp(1'b0, 1'b0), "start_abort_idle");
    step(1'b0, 1'b0, idle_exp(1'b0, 1'b0), "start_abort_after");

    // abort on the edge where FLUSH would complete: abort wins, no done.
    step(1'b1, 1'b0, exp_run(0), "abf_c0");
    run_span(1, 79, 1'b0, "abf");
    step(1'b0, 1'b1, idle_exp(1'b0, 1'b1), "abort_flush_end");
    step(1'b0, 1'b0, idle_exp(1'b0, 1'b0), "abort_flush_after");

    // start held high: next run begins on the edge after the done cycle.
    step(1'b1, 1'b0, exp_run(0), "held_c0");
    run_span(1, 80, 1'b1, "held");
    step(1'b1, 1'b0, exp_run(0), "back_to_back");
    run_span(1, 5, 1'b0, "held2");
    step(1'b0, 1'b1, idle_exp(1'b0, 1'b1), "abort_load");
    step(1'b0, 1'b0, idle_exp(1'b0, 1'b0), "abort_load_after");

    // Asynchronous reset mid-INC, then a full run afterwards.
    step(1'b1, 1'b0, exp_run(0), "ar_c0");
    run_span(1, 60, 1'b0, "ar");
    #2 rst = 1'b1;
    #1;
    sb_q.push_back(idle_exp(1'b0, 1'b0));
    check("async_rst_mid_inc");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, exp_run(0), "run2_c0");
    run_span(1, 80, 1'b0, "run2");
    step(1'b0, 1'b0, idle_exp(1'b0, 1'b0), "run2_after_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/kinase_activity_ctrl.md
Name: kinase_activity_ctrl

Overview:
- Control-side sequencer for the dual kinase_activity chip array. It drives the shared control bus: 13 valve lines c, 4 sieve lines s and 5 pump lines p.
- It sequences one assay run through five phases: load, peristaltic mix, incubate, flush, return to idle. It is the pneumatic-manifold end of the control interface that the chips consume.
- It handles start/busy/done handshaking with the host and aborts to a safe all-closed state.

Parameters:
LOAD_CYC, 8, cycles spent in LOAD (values below 1 are treated as 1)
STEP_CYC, 4, cycles each pump pattern step is held (values below 1 are treated as 1)
MIX_REPS, 2, number of full 6-step peristaltic cycles in MIX (values below 1 are treated as 1)
INC_CYC, 16, cycles spent in INCUBATE (values below 1 are treated as 1)
FLUSH_CYC, 8, cycles spent in FLUSH (values below 1 are treated as 1)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  level; forces the safe state from any phase
c  output  13  valve lines: c[2:0] inlets, c[6:3] outlets, c[12:7] isolation (1 = pressurised/closed)
s  output  4  sieve valve lines (1 = actuated)
p  output  5  pump lines: p[2:0] mix ring, p[4:3] flush pump (1 = actuated)
busy  output  1  high while in any phase other than IDLE
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse when an abort terminates a run
phase  output  3  current state code: IDLE=0, LOAD=1, MIX=2, INC=3, FLUSH=4

Behaviour:
- All outputs are registered. Output vectors change on the same edge as the state register.
- Reset (asynchronous, any time, including mid-run): state IDLE, c=13'h1FFF, s=4'h0, p=5'h00, busy=0, done=0, aborted=0, phase=0, all counters 0.
- Per-phase outputs:
  - IDLE: c=13'h1FFF, s=4'h0, p=5'h00.
  - LOAD: c=13'h0078, s=4'hF, p=5'h00.
  - MIX: c=13'h007F, s=4'hF, p[4:3]=00. p[2:0] steps through 101, 100, 110, 010, 011, 001, each held STEP_CYC cycles, repeated MIX_REPS times.
  - INC: c=13'h1FFF, s=4'hF, p=5'h00.
  - FLUSH: c=13'h0006, s=4'h0, p[2:0]=000. p[4:3] starts at 10 and toggles 10/01 every STEP_CYC cycles.
- Transitions:
  - IDLE→LOAD on an edge with start=1 and abort=0.
  - LOAD→MIX after LOAD_CYC cycles.
  - MIX→INC after MIX_REPS*6*STEP_CYC cycles.
  - INC→FLUSH after INC_CYC cycles.
  - FLUSH→IDLE after FLUSH_CYC cycles. done=1 for the one cycle following that edge.
- Timing with defaults: start sampled at edge 0, then LOAD for 8 cycles, MIX 48, INC 16, FLUSH 8. IDLE is re-entered at edge 80 with done high during cycle 80.
- The phase counter is 16 bits wide and clears on every state change. The step counter and pattern index clear on MIX/FLUSH entry. The pattern index wraps 5→0.
- start while busy is ignored. It is not queued.
- abort=1 in any non-IDLE state: next edge goes to IDLE with the IDLE vectors, aborted=1 for one cycle, done stays 0.
- abort=1 in IDLE: no effect, including when start=1 in the same cycle (abort wins, no run begins, aborted stays 0).
- abort on the same edge that FLUSH would complete: abort wins; aborted=1, done=0.
- start held high continuously: a new run begins on the first edge after done, while IDLE is sampled with start=1. The cycle carrying done counts as IDLE.
- done and aborted are never high together. Neither is ever high while busy=1.

Test Plan:
1. Reset, then one-cycle start with default parameters -> busy rises after edge 0; phase sequence 1,2,3,4 entered at edges 0,8,56,72; done pulses in cycle 80; c returns to 13'h1FFF.
2. Sample p[2:0] every 4 cycles during MIX -> exactly 101,100,110,010,011,001 twice, with p[4:3]=00 throughout.
3. Sample p[4:3] during FLUSH -> 10 for 4 cycles then 01 for 4 cycles; c=13'h0006 and s=0.
4. Assert abort in MIX at cycle 20 -> next edge phase=0, c=13'h1FFF, p=0, aborted one cycle, done never asserted.
5. Pulse start again at cycle 30 of a run, and assert start and abort together in IDLE -> no restart and no extra done; no run starts and aborted stays 0.
6. Assert rst asynchronously mid-INC -> outputs go to reset values immediately, without waiting for a clock edge; a later start runs a full 80-cycle sequence.
